reg_file_bus_bridge: RTL and testbench



---
 rtl/reg_file_bridge_pkg.sv | 25 ++
 rtl/ifc_reg_file_direct_access.sv | 15 +
 rtl/reg_file_bus_bridge.sv | 175 +++++++++++++++++
 tb/tb_reg_file_bus_bridge.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/reg_file_bridge_pkg.sv
// Shared types and helpers for the register-file bus bridge.
package reg_file_bridge_pkg;

  // Bridge transaction states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    SETTLE = 2'd2,
    RESP   = 2'd3
  } bridge_state_e;

  // One byte lane of a read-modify-write: strobe set takes the new byte.
  function automatic logic [7:0] strobe_merge(input logic [7:0] new_byte,
                                              input logic [7:0] old_byte,
                                              input logic       strb);
    return strb ? new_byte : old_byte;
  endfunction

  // Byte address to register index; sub-word address bits are discarded.
  function automatic logic [31:0] addr_to_idx(input logic [31:0]   addr,
                                              input int unsigned   byte_shift);
    return addr >> byte_shift;
  endfunction

endpackage

// File: rtl/ifc_reg_file_direct_access.sv
// Direct-access register file interface: per-register write pulses with a
// shared data bus per lane, plus a parallel view of every register's value.
interface ifc_reg_file_direct_access #(
  parameter int unsigned REGISTER_WIDTH = 32,
  parameter int unsigned NUM_REGISTERS  = 16
);

  logic [NUM_REGISTERS-1:0]                     write_req;
  logic [NUM_REGISTERS-1:0][REGISTER_WIDTH-1:0] write_data;
  logic [NUM_REGISTERS-1:0][REGISTER_WIDTH-1:0] read_data;

  modport master (output write_req, output write_data, input read_data);
  modport slave  (input write_req, input write_data, output read_data);

endinterface

// File: rtl/reg_file_bus_bridge.sv
// Bridge from a single-outstanding valid/ready request/response bus to the
// direct-access register file interface. Writes are byte-strobed
// read-modify-writes; out-of-range indices answer with an error response.
// ADDR_WIDTH is assumed to be at most 32.
module reg_file_bus_bridge
  import reg_file_bridge_pkg::*;
#(
  parameter int unsigned REGISTER_WIDTH      = 32,
  parameter int unsigned NUM_REGISTERS       = 16,
  parameter int unsigned ADDR_WIDTH          = 8,
  parameter int unsigned WRITE_SETTLE_CYCLES = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_write,
  input  logic [ADDR_WIDTH-1:0]       req_addr,
  input  logic [REGISTER_WIDTH-1:0]   req_wdata,
  input  logic [REGISTER_WIDTH/8-1:0] req_wstrb,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [REGISTER_WIDTH-1:0]   rsp_rdata,
  output logic                        rsp_err,
  ifc_reg_file_direct_access.master   reg_if
);

  localparam int unsigned NUM_BYTES  = REGISTER_WIDTH / 8;
  localparam int unsigned BYTE_SHIFT = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 0;
  localparam int unsigned IDX_W      = (NUM_REGISTERS > 1) ? $clog2(NUM_REGISTERS) : 1;
  // Counter load value: SETTLE exits when the counter reaches zero.
  localparam logic [3:0]  SETTLE_LOAD =
    (WRITE_SETTLE_CYCLES == 0) ? 4'd0 : 4'(WRITE_SETTLE_CYCLES - 1);

  bridge_state_e               state_q, state_d;
  logic                        req_ready_q, req_ready_d;
  logic                        rsp_valid_q, rsp_valid_d;
  logic [REGISTER_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                        rsp_err_q, rsp_err_d;
  logic [NUM_REGISTERS-1:0]    write_req_q, write_req_d;
  logic [REGISTER_WIDTH-1:0]   wdata_q, wdata_d;
  logic [3:0]                  cnt_q, cnt_d;

  logic [31:0]                 idx_s;
  logic [IDX_W-1:0]            idx_lo_s;
  logic                        in_range_s;
  logic [REGISTER_WIDTH-1:0]   old_s;
  logic [REGISTER_WIDTH-1:0]   merged_s;
  logic [NUM_REGISTERS-1:0]    onehot_s;

  assign idx_s      = addr_to_idx(32'(req_addr), BYTE_SHIFT);
  assign idx_lo_s   = idx_s[IDX_W-1:0];
  assign in_range_s = (idx_s < 32'(NUM_REGISTERS));
  assign old_s      = reg_if.read_data[idx_lo_s];

  // Byte-strobe merge of the request data over the current register value.
  always_comb begin
    merged_s = '0;
    for (int b = 0; b < int'(NUM_BYTES); b++) begin
      merged_s[b*8 +: 8] = strobe_merge(req_wdata[b*8 +: 8], old_s[b*8 +: 8], req_wstrb[b]);
    end
  end

  // One-hot decode of the requested register index.
  always_comb begin
    onehot_s           = '0;
    onehot_s[idx_lo_s] = 1'b1;
  end

  // Next-state and registered-output computation for the transaction FSM.
  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    write_req_d = '0;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (!in_range_s) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
            state_d     = RESP;
          end else if (req_write) begin
            wdata_d     = merged_s;
            write_req_d = onehot_s;
            state_d     = WRITE;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = old_s;
            rsp_err_d   = 1'b0;
            state_d     = RESP;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        if (WRITE_SETTLE_CYCLES == 0) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          state_d     = RESP;
        end else begin
          cnt_d   = SETTLE_LOAD;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == 4'd0) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Ready only while idle; the handshake cycle itself never accepts.
    req_ready_d = (state_d == IDLE);
  end

  // State and output registers; reset drops any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      write_req_q <= '0;
      wdata_q     <= '0;
      cnt_q       <= 4'd0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      write_req_q <= write_req_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  assign reg_if.write_req = write_req_q;

  // Every lane carries the captured write data; write_req picks the target.
  for (genvar g = 0; g < int'(NUM_REGISTERS); g++) begin : g_wdata
    assign reg_if.write_data[g] = wdata_q;
  end

endmodule

// File: tb/tb_reg_file_bus_bridge.sv
// Directed self-checking bench for reg_file_bus_bridge (32/16/8, settle=2).
module tb_reg_file_bus_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [7:0]  req_addr = 8'h00;
  logic [31:0] req_wdata = 32'h0;
  logic [3:0]  req_wstrb = 4'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  ifc_reg_file_direct_access #(.REGISTER_WIDTH(32), .NUM_REGISTERS(16)) rf_if ();

  reg_file_bus_bridge #(
    .REGISTER_WIDTH(32), .NUM_REGISTERS(16), .ADDR_WIDTH(8), .WRITE_SETTLE_CYCLES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .reg_if(rf_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance one clock edge and land on the following falling edge.
  task automatic nxt();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic wr, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_wstrb = s;
    nxt();
    req_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf_if.read_data[i] = 32'h0101_0101 * 32'(i);
    rf_if.read_data[3]  = 32'hDEADBEEF;
    rf_if.read_data[2]  = 32'hAABBCCDD;
    rf_if.read_data[9]  = 32'h55667788;
    rf_if.read_data[15] = 32'hCAFEF00D;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_write_req", 64'(rf_if.write_req), 64'd0);
    chk("rst_write_data", 64'(rf_if.write_data[7]), 64'd0);

    // Read of register 3.
    issue(1'b0, 8'h0C, 32'h0, 4'h0);
    chk("rd_valid", 64'(rsp_valid), 64'd1);
    chk("rd_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
    chk("rd_err", 64'(rsp_err), 64'd0);
    chk("rd_wreq", 64'(rf_if.write_req), 64'd0);
    chk("rd_ready_busy", 64'(req_ready), 64'd0);
    nxt();
    chk("rd_valid_drop", 64'(rsp_valid), 64'd0);
    chk("rd_ready_back", 64'(req_ready), 64'd1);

    // Read with ignored low address bits, then the highest register.
    issue(1'b0, 8'h0F, 32'h0, 4'h0);
    chk("rd_lowbits", 64'(rsp_rdata), 64'hDEADBEEF);
    nxt();
    issue(1'b0, 8'h3C, 32'h0, 4'h0);
    chk("rd_top_rdata", 64'(rsp_rdata), 64'hCAFEF00D);
    chk("rd_top_err", 64'(rsp_err), 64'd0);
    nxt();

    // Full write to register 5.
    issue(1'b1, 8'h14, 32'h12345678, 4'hF);
    chk("wr_c1_wreq", 64'(rf_if.write_req), 64'h0020);
    chk("wr_c1_data", 64'(rf_if.write_data[5]), 64'h12345678);
    chk("wr_c1_valid", 64'(rsp_valid), 64'd0);
    nxt();
    chk("wr_c2_wreq", 64'(rf_if.write_req), 64'd0);
    chk("wr_c2_data_hold", 64'(rf_if.write_data[5]), 64'h12345678);
    chk("wr_c2_valid", 64'(rsp_valid), 64'd0);
    nxt();
    chk("wr_c3_valid", 64'(rsp_valid), 64'd0);
    nxt();
    chk("wr_c4_valid", 64'(rsp_valid), 64'd1);
    chk("wr_c4_rdata", 64'(rsp_rdata), 64'd0);
    chk("wr_c4_err", 64'(rsp_err), 64'd0);
    nxt();
    chk("wr_done_valid", 64'(rsp_valid), 64'd0);
    chk("wr_done_ready", 64'(req_ready), 64'd1);

    // Partial write: bytes 0 and 2 from the request, 1 and 3 kept.
    issue(1'b1, 8'h08, 32'h11223344, 4'b0101);
    chk("pw_wreq", 64'(rf_if.write_req), 64'h0004);
    chk("pw_data", 64'(rf_if.write_data[2]), 64'hAA22CC44);
    chk("pw_lane_other", 64'(rf_if.write_data[11]), 64'hAA22CC44);
    repeat (3) nxt();
    chk("pw_valid", 64'(rsp_valid), 64'd1);
    nxt();

    // Zero strobe still pulses with the unchanged value.
    issue(1'b1, 8'h24, 32'hFFFFFFFF, 4'h0);
    chk("zs_wreq", 64'(rf_if.write_req), 64'h0200);
    chk("zs_data", 64'(rf_if.write_data[9]), 64'h55667788);
    repeat (4) nxt();

    // Out-of-range read and write.
    issue(1'b0, 8'h40, 32'h0, 4'h0);
    chk("oor_rd_valid", 64'(rsp_valid), 64'd1);
    chk("oor_rd_err", 64'(rsp_err), 64'd1);
    chk("oor_rd_rdata", 64'(rsp_rdata), 64'd0);
    nxt();
    chk("oor_rd_clear", 64'(rsp_err), 64'd0);
    issue(1'b1, 8'hFF, 32'h87654321, 4'hF);
    chk("oor_wr_valid", 64'(rsp_valid), 64'd1);
    chk("oor_wr_err", 64'(rsp_err), 64'd1);
    chk("oor_wr_wreq", 64'(rf_if.write_req), 64'd0);
    chk("oor_wr_data_kept", 64'(rf_if.write_data[0]), 64'h55667788);
    nxt();

    // Response backpressure: outputs frozen while rsp_ready is low.
    rsp_ready = 1'b0;
    issue(1'b0, 8'h0C, 32'h0, 4'h0);
    rf_if.read_data[3] = 32'h0BADF00D;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
      chk("bp_err", 64'(rsp_err), 64'd0);
      chk("bp_ready", 64'(req_ready), 64'd0);
      nxt();
    end
    chk("bp_still_valid", 64'(rsp_valid), 64'd1);
    rsp_ready = 1'b1;
    nxt();
    chk("bp_done_valid", 64'(rsp_valid), 64'd0);
    chk("bp_done_ready", 64'(req_ready), 64'd1);

    // Reset while the write pulse is high drops it asynchronously.
    issue(1'b1, 8'h18, 32'h5A5A5A5A, 4'hF);
    chk("rw_pulse", 64'(rf_if.write_req), 64'h0040);
    rst_n = 1'b0;
    #1;
    chk("rw_pulse_drop", 64'(rf_if.write_req), 64'd0);
    chk("rw_data_clear", 64'(rf_if.write_data[6]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset during SETTLE: no response, idle afterwards.
    issue(1'b1, 8'h04, 32'hA5A5A5A5, 4'hF);
    chk("rs_pulse", 64'(rf_if.write_req), 64'h0002);
    nxt();
    rst_n = 1'b0;
    #1;
    chk("rs_valid", 64'(rsp_valid), 64'd0);
    chk("rs_wreq", 64'(rf_if.write_req), 64'd0);
    chk("rs_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      nxt();
      chk("rs_no_stale", 64'(rsp_valid), 64'd0);
    end
    chk("rs_ready_after", 64'(req_ready), 64'd1);

    // Bridge is usable after the reset.
    issue(1'b0, 8'h0C, 32'h0, 4'h0);
    chk("post_rst_rdata", 64'(rsp_rdata), 64'h0BADF00D);
    nxt();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
